// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//
// Contents:
//   state_t       - controller states (IDLE, RUN, DONE)
//   SAT_MAX_WIDTH - widest operand the saturation helper can describe
//   satValue()    - saturated signed constant for a given width and sign
//
// The saturation helper is only referenced when ADDSUB_DIGIT_SAT_EN is
// defined.

package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SAT_MAX_WIDTH = 256;

    // Returns the most positive value (0 followed by ones) when negative is 0,
    // or the most negative value (1 followed by zeros) when negative is 1.
    // Bits above 'width' are zero so the caller can size-cast the result.
    function automatic logic [SAT_MAX_WIDTH-1:0] satValue(input int width, input logic negative);
        logic [SAT_MAX_WIDTH-1:0] value;
        value = '0;
        for (int i = 0; i < SAT_MAX_WIDTH; i++) begin
            if (i < width) begin
                value[i] = (i == width - 1) ? negative : ~negative;
            end
        end
        return value;
    endfunction

endpackage

// File: rtl/fa_digit.sv
// Combinational DIGIT-bit ripple-carry slice.
//
// Ports:
//   a, b  [DIGIT-1:0] in  - operand digits
//   cin               in  - carry into bit 0
//   sum   [DIGIT-1:0] out - digit sum
//   cout              out - carry out of the top bit
//   cmsb              out - carry into the top bit (used for overflow)

module fa_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT:0] w_carry;

    // Classic ripple: each bit's carry feeds the next full adder.
    always_comb begin
        w_carry    = '0;
        sum        = '0;
        w_carry[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]       = a[i] ^ b[i] ^ w_carry[i];
            w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = w_carry[DIGIT];
    assign cmsb = w_carry[DIGIT-1];

endmodule

// File: rtl/addsub_digit_serial.sv
// Digit-serial signed/unsigned adder-subtractor with valid/ready handshakes.
// Operands are consumed DIGIT bits per clock, LSB first, so a result takes
// N = WIDTH/DIGIT compute cycles.
//
// Ports:
//   clk, rst            - clock (rising edge), async active-high reset
//   in_valid/in_ready   - operand handshake (ready only in IDLE)
//   A, B [WIDTH-1:0]    - operands, sampled on the accepting edge
//   sel                 - 0 = A+B, 1 = A-B
//   out_valid/out_ready - result handshake (valid only in DONE)
//   S [WIDTH-1:0]       - sum/difference
//   Ci                  - carry out of bit WIDTH-1 (subtract: 1 = no borrow)
//   Ov                  - two's-complement signed overflow
//
// Optional feature: define ADDSUB_DIGIT_SAT_EN to saturate S on overflow.

module addsub_digit_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Ci,
    output logic             Ov
);

    import addsub_pkg::*;

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_badParams
        $error("addsub_digit_serial: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t           r_state;
    state_t           w_stateNext;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [WIDTH-1:0] r_s;
    logic             r_ci;
    logic             r_ov;

    logic [DIGIT-1:0] w_sum;
    logic             w_cout;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_resNext;
    logic [WIDTH-1:0] w_sNext;
    logic             w_lastDigit;

    fa_digit #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a    (r_a[DIGIT-1:0]),
        .b    (r_b[DIGIT-1:0]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout),
        .cmsb (w_cmsb)
    );

    // New digits enter at the top, so after N shifts the first digit has
    // walked down to bit 0 and the register holds the full result.
    if (N == 1) begin : g_singleDigit
        assign w_resNext = w_sum;
    end else begin : g_multiDigit
        assign w_resNext = {w_sum, r_res[WIDTH-1:DIGIT]};
    end

    assign w_lastDigit = (r_state == RUN) && (r_count == CW'(N - 1));

`ifdef ADDSUB_DIGIT_SAT_EN
    // Sign of A is lost from the shift register, so keep it separately.
    logic             r_aSign;
    logic [WIDTH-1:0] w_sat;

    if (WIDTH > SAT_MAX_WIDTH) begin : g_satTooWide
        $error("addsub_digit_serial: WIDTH exceeds SAT_MAX_WIDTH");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aSign <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_aSign <= A[WIDTH-1];
        end
    end

    assign w_sat   = WIDTH'(satValue(WIDTH, r_aSign));
    assign w_sNext = (w_cmsb ^ w_cout) ? w_sat : w_resNext;
`else
    assign w_sNext = w_resNext;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (in_valid)    w_stateNext = RUN;
            RUN:     if (w_lastDigit) w_stateNext = DONE;
            DONE:    if (out_ready)   w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: B is inverted on capture and the carry
    // register starts at sel, so the slice never needs to know the mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_ci    <= 1'b0;
            r_ov    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= A;
                        r_b     <= B ^ {WIDTH{sel}};
                        r_carry <= sel;
                        r_count <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_res   <= w_resNext;
                    r_carry <= w_cout;
                    r_count <= r_count + CW'(1);
                    if (w_lastDigit) begin
                        r_s  <= w_sNext;
                        r_ci <= w_cout;
                        r_ov <= w_cmsb ^ w_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign S         = r_s;
    assign Ci        = r_ci;
    assign Ov        = r_ov;

endmodule

// File: tb/tb_addsub_digit_serial.sv
// Self-checking bench for addsub_digit_serial (WIDTH=8, DIGIT=2).
// Directed vectors from a table, randomized operations checked against an
// arithmetic reference model, and hand-written backpressure / reset sequences.

module tb_addsub_digit_serial;

    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int N     = WIDTH / DIGIT;

`ifdef ADDSUB_DIGIT_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    typedef struct {
        logic [7:0] s;
        logic       ci;
        logic       ov;
    } resultT;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sel;
        logic [7:0] expS;
        logic       expCi;
        logic       expOv;
    } vectorT;

    logic       clock;
    logic       reset;
    logic       inValid;
    logic       inReady;
    logic [7:0] opA;
    logic [7:0] opB;
    logic       sel;
    logic       outValid;
    logic       outReady;
    logic [7:0] sOut;
    logic       ciOut;
    logic       ovOut;

    int checkCount;
    int passCount;

    addsub_digit_serial #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk       (clock),
        .rst       (reset),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .A         (opA),
        .B         (opB),
        .sel       (sel),
        .out_valid (outValid),
        .out_ready (outReady),
        .S         (sOut),
        .Ci        (ciOut),
        .Ov        (ovOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic resultT model(input logic [7:0] a, input logic [7:0] b, input logic s);
        resultT r;
        int ua, ub, sa, sb, exact;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        exact = s ? (sa - sb) : (sa + sb);
        r.ci  = s ? (ua >= ub) : ((ua + ub) > 255);
        r.ov  = (exact > 127) || (exact < -128);
        r.s   = exact[7:0];
        if (SAT && r.ov) r.s = (sa < 0) ? 8'h80 : 8'h7F;
        return r;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic checkOutput(input string name, input resultT exp, input int latency);
        checkValue({name, " latency"}, 32'(latency), 32'(N));
        checkValue({name, " S"}, {24'd0, sOut}, {24'd0, exp.s});
        checkValue({name, " Ci"}, {31'd0, ciOut}, {31'd0, exp.ci});
        checkValue({name, " Ov"}, {31'd0, ovOut}, {31'd0, exp.ov});
    endtask

    // Presents one operation, counts edges until out_valid (bounded), and
    // leaves the DUT in DONE with the result on the outputs.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic s, output int latency);
        @(negedge clock);
        opA = a;
        opB = b;
        sel = s;
        inValid = 1'b1;
        @(posedge clock);
        #1;
        inValid = 1'b0;
        opA = 8'($urandom);
        opB = 8'($urandom);
        sel = ~s;
        latency = 0;
        while (!outValid && latency < 20) begin
            @(posedge clock);
            #1;
            latency++;
        end
    endtask

    task automatic releaseOutput();
        @(negedge clock);
        outReady = 1'b1;
        @(posedge clock);
        #1;
        outReady = 1'b0;
    endtask

    vectorT vecs[8];
    resultT exp;
    int     lat;

    initial begin
        checkCount = 0;
        passCount  = 0;
        reset    = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b0;
        opA = 8'h00;
        opB = 8'h00;
        sel = 1'b0;

        vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h47, 1'b0, 1'b0};
        vecs[1] = '{8'h12, 8'h35, 1'b1, 8'hDD, 1'b0, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h01, 1'b1, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 1'b0, SAT ? 8'h80 : 8'h00, 1'b1, 1'b1};
        vecs[7] = '{8'h7F, 8'hFF, 1'b1, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1};

        #2;
        checkValue("reset outputs", {21'd0, outValid, inReady, ciOut, ovOut, sOut},
                   {21'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkValue("in_ready after reset", {31'd0, inReady}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sel, lat);
            exp.s  = vecs[i].expS;
            exp.ci = vecs[i].expCi;
            exp.ov = vecs[i].expOv;
            checkOutput($sformatf("vec%0d", i), exp, lat);
            releaseOutput();
        end

        // Backpressure: result must hold and new operands must be ignored.
        applyStimulus(8'h35, 8'h12, 1'b0, lat);
        checkOutput("bp op", model(8'h35, 8'h12, 1'b0), lat);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            inValid = 1'b1;
            opA = 8'($urandom);
            opB = 8'($urandom);
            sel = 1'($urandom);
            @(posedge clock);
            #1;
            checkValue($sformatf("bp hold %0d", i), {21'd0, outValid, inReady, ciOut, ovOut, sOut},
                       {21'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h47});
        end
        @(negedge clock);
        inValid = 1'b0;
        outReady = 1'b1;
        @(posedge clock);
        #1;
        outReady = 1'b0;
        checkValue("bp release", {30'd0, inReady, outValid}, {30'd0, 1'b1, 1'b0});
        repeat (6) @(posedge clock);
        #1;
        checkValue("bp no stray op", {31'd0, outValid}, 32'd0);
        applyStimulus(8'hA5, 8'h3C, 1'b1, lat);
        checkOutput("after bp", model(8'hA5, 8'h3C, 1'b1), lat);
        releaseOutput();

        // Reset during the second RUN cycle.
        @(negedge clock);
        opA = 8'hC3;
        opB = 8'h5A;
        sel = 1'b0;
        inValid = 1'b1;
        @(posedge clock);
        #1;
        inValid = 1'b0;
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        checkValue("mid-run reset", {21'd0, outValid, inReady, ciOut, ovOut, sOut},
                   {21'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkValue("post reset ready", {30'd0, inReady, outValid}, {30'd0, 1'b1, 1'b0});
        applyStimulus(8'h01, 8'h01, 1'b0, lat);
        exp.s  = 8'h02;
        exp.ci = 1'b0;
        exp.ov = 1'b0;
        checkOutput("after reset", exp, lat);
        releaseOutput();

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic       rs;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            applyStimulus(ra, rb, rs, lat);
            checkOutput($sformatf("rand%0d", i), model(ra, rb, rs), lat);
            releaseOutput();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/addsub_digit_serial.md
Name: addsub_digit_serial

Overview:
- Parametrised, multi-cycle signed/unsigned adder-subtractor. Successor to the 4-bit ripple add/sub cell.
- Processes DIGIT bits per clock, LSB-first, through a DIGIT-wide full-adder slice. This trades latency for area at large WIDTH.
- Valid/ready on both input and output sides, so it drops into lab datapaths between register stages.
- Reports carry/borrow and signed overflow, with optional saturation.

Parameters:
- WIDTH, 8: operand/result width in bits. Must be >= 2.
- DIGIT, 2: bits processed per cycle. WIDTH % DIGIT must be 0; elaboration error otherwise.
- Derived N = WIDTH/DIGIT, the number of compute cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- sel  in  1  0 = A+B, 1 = A-B.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- S  out  WIDTH  sum/difference.
- Ci  out  1  final carry out. For subtract, 1 = no borrow.
- Ov  out  1  two's-complement signed overflow.

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, all internal regs 0, S=0, Ci=0, Ov=0, out_valid=0.
  - in_ready goes high in the first cycle after rst deasserts.
  - An operation in flight is discarded with no output.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE:
  - On an edge with in_valid && in_ready: latch A, latch B^{WIDTH{sel}}, latch sel.
  - Carry reg = sel; counter = 0; go to RUN.
  - A/B/sel are sampled only on this edge; changes in other states are ignored.
- RUN, each edge:
  - Slice adds the low DIGIT bits of the A/B shift regs with carry reg.
  - Sum digit is shifted into the top of the result shift reg; A/B shift right by DIGIT.
  - Carry reg updates; counter increments.
  - On the edge where counter == N-1: go to DONE, and load S, Ci, Ov from the completed result.
- Latency: out_valid rises exactly N edges after the accepting edge. With N=1 (DIGIT=WIDTH), DONE follows the accept edge by one edge.
- Ci = carry out of bit WIDTH-1.
- Ov = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. The slice exposes carry into its MSB for this.
- DONE:
  - S/Ci/Ov held stable while out_ready is low (backpressure), for any duration.
  - On an edge with out_ready: go to IDLE.
  - No input accept in the same edge; minimum issue interval is N+2 cycles.
- S/Ci/Ov keep the last result until the next DONE entry or reset. Consumers qualify them with out_valid.
- in_valid held high across DONE→IDLE: accepted on the first IDLE edge.

Optional Feature:
- Macro ADDSUB_DIGIT_SAT_EN.
- Defined: when Ov=1, S is loaded with the saturated signed value instead of the wrapped sum.
  - If the latched A[WIDTH-1] is 0, S = 0 followed by all ones (max positive).
  - If it is 1, S = 1 followed by all zeros (min negative).
  - Ov and Ci still report the raw result. Latency is unchanged.
- Undefined: wrap-around two's-complement result. No saturation logic is present.

Decomposition:
- Package addsub_pkg:
  - state enum (IDLE, RUN, DONE).
  - function computing the saturation constant for a given width and sign.
- Sub-module fa_digit, parametrised by DIGIT: combinational ripple of full adders.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and carry into MSB.
  - Instantiated once; it holds no state.
- Top holds the FSM, counter, shift regs and output regs.

Test Plan:
- Config WIDTH=8, DIGIT=2, so N=4.
- Add: A=8'h35, B=8'h12, sel=0 → S=8'h47, Ci=0, Ov=0; out_valid exactly 4 edges after accept.
- Subtract with borrow: A=8'h12, B=8'h35, sel=1 → S=8'hDD, Ci=0, Ov=0.
- Positive overflow: A=8'h7F, B=8'h01, sel=0 → S=8'h80, Ov=1, Ci=0. With ADDSUB_DIGIT_SAT_EN: S=8'h7F, Ov=1.
- Negative overflow: A=8'h80, B=8'h01, sel=1 → S=8'h7F, Ov=1, Ci=1. With the macro: S=8'h80.
- Backpressure: out_ready held low 6 cycles in DONE with new in_valid pulses and changing A/B → S/Ci/Ov stable, in_ready=0, the new operands are not taken. Releasing out_ready gives IDLE; the next op is accepted and gives a correct result.
- Reset mid-RUN: rst asserted at the 2nd RUN cycle → out_valid=0, S=0, Ci=0, Ov=0 immediately (async). in_ready=1 after release. A following A=8'h01, B=8'h01, sel=0 gives S=8'h02.
